// File: rtl/alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
//   ID-stage instruction decoder plus the ID/EX control register of the
//   pipelined MIPS core. This block produces the ALU control word, the
//   immediate operand and the writeback controls, and registers all of them
//   at the ID/EX boundary. The register can hold its contents (stall) and can
//   be replaced with a bubble (flush).
//
//   Optional feature macro: DECODE_IMM_EN
//     defined   -> I-type ALU instructions are decoded
//                  (addi, addiu, slti, andi, ori, xori, lui)
//     undefined -> every nonzero opcode is illegal; imm32 and alu_src_imm
//                  stay 0
//
// Ports
//   clk          core clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   in_valid     instr holds a valid IF/ID instruction
//   instr        32-bit instruction word
//   stall        hold the ID/EX contents
//   flush        replace the ID/EX contents with a bubble
//   ex_valid     ID/EX slot holds an instruction
//   const_amt    constant shift amount (shamt, or 16 for lui)
//   amt_sel      0 = const_amt, 1 = x[4:0]
//   shift_func   0 none, 1 sll, 2 srl, 3 sra
//   logic_func   0 and, 1 or, 2 xor, 3 nor
//   add_sub      1 = subtract
//   final_func   0 shifter, 1 slt, 2 adder, 3 logic
//   alu_src_imm  1 = ALU y operand is imm32
//   imm32        extended immediate
//   ovf_chk      trap on ALU overflow (add, sub, addi)
//   reg_write    write the result to dest_reg
//   dest_reg     rd for R-type, rt for I-type
//   illegal      unsupported encoding
// -----------------------------------------------------------------------------
module alu_ctrl_decode #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [4:0]        const_amt,
  output logic [1:0]        amt_sel,
  output logic [1:0]        shift_func,
  output logic [1:0]        logic_func,
  output logic              add_sub,
  output logic [1:0]        final_func,
  output logic              alu_src_imm,
  output logic [DATA_W-1:0] imm32,
  output logic              ovf_chk,
  output logic              reg_write,
  output logic [REG_AW-1:0] dest_reg,
  output logic              illegal
);

  localparam logic [1:0] FF_SHIFT = 2'd0;
  localparam logic [1:0] FF_SLT   = 2'd1;
  localparam logic [1:0] FF_ADD   = 2'd2;
  localparam logic [1:0] FF_LOGIC = 2'd3;

  typedef struct packed {
    logic              ex_valid;
    logic [4:0]        const_amt;
    logic [1:0]        amt_sel;
    logic [1:0]        shift_func;
    logic [1:0]        logic_func;
    logic              add_sub;
    logic [1:0]        final_func;
    logic              alu_src_imm;
    logic [DATA_W-1:0] imm32;
    logic              ovf_chk;
    logic              reg_write;
    logic [REG_AW-1:0] dest_reg;
    logic              illegal;
  } ctrl_t;

  // A bubble is all zero except final_func, which idles on the adder.
  function automatic ctrl_t bubble();
    ctrl_t c;
    c            = '0;
    c.final_func = FF_ADD;
    return c;
  endfunction

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [4:0]        w_shamt;
  logic              w_illegal;
  ctrl_t             w_dec;
  ctrl_t             r_ctrl;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_rt     = instr[20:16];
  assign w_rd     = instr[15:11];
  assign w_shamt  = instr[10:6];

  always_comb begin
    // NOTE: every field gets a default before the case statements so no
    // path through this block leaves a value unassigned (no latches).
    w_dec     = bubble();
    w_illegal = 1'b0;
    if (in_valid) begin
      w_dec.ex_valid = 1'b1;
      if (w_opcode == 6'h00) begin
        w_dec.dest_reg = w_rd;
        unique case (w_funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
            w_dec.final_func = FF_SHIFT;
            // funct[1:0] is 0/2/3 for sll/srl/sra; map 0 -> sll code 1.
            w_dec.shift_func = (w_funct[1:0] == 2'd0) ? 2'd1 : w_funct[1:0];
            w_dec.amt_sel    = {1'b0, w_funct[2]};
            w_dec.const_amt  = w_funct[2] ? 5'd0 : w_shamt;
          end
          6'h20, 6'h21, 6'h22, 6'h23: begin
            w_dec.final_func = FF_ADD;
            w_dec.add_sub    = w_funct[1];
            w_dec.ovf_chk    = ~w_funct[0];
          end
          6'h24, 6'h25, 6'h26, 6'h27: begin
            w_dec.final_func = FF_LOGIC;
            w_dec.logic_func = w_funct[1:0];
          end
          6'h2A: begin
            w_dec.final_func = FF_SLT;
            w_dec.add_sub    = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
`ifdef DECODE_IMM_EN
      else begin
        w_dec.dest_reg    = w_rt;
        w_dec.alu_src_imm = 1'b1;
        unique case (w_opcode)
          6'h08, 6'h09: begin
            w_dec.final_func = FF_ADD;
            w_dec.imm32      = {{(DATA_W-16){instr[15]}}, instr[15:0]};
            w_dec.ovf_chk    = ~w_opcode[0];
          end
          6'h0A: begin
            w_dec.final_func = FF_SLT;
            w_dec.add_sub    = 1'b1;
            w_dec.imm32      = {{(DATA_W-16){instr[15]}}, instr[15:0]};
          end
          6'h0C, 6'h0D, 6'h0E: begin
            w_dec.final_func = FF_LOGIC;
            w_dec.logic_func = w_opcode[1:0];
            w_dec.imm32      = {{(DATA_W-16){1'b0}}, instr[15:0]};
          end
          6'h0F: begin
            // lui reuses the shifter: zero-extended imm16 shifted left by 16.
            w_dec.final_func = FF_SHIFT;
            w_dec.shift_func = 2'd1;
            w_dec.const_amt  = 5'd16;
            w_dec.imm32      = {{(DATA_W-16){1'b0}}, instr[15:0]};
          end
          default: w_illegal = 1'b1;
        endcase
      end
`else
      else begin
        w_illegal = 1'b1;
      end
`endif
      if (w_illegal) begin
        w_dec          = bubble();
        w_dec.ex_valid = 1'b1;
        w_dec.illegal  = 1'b1;
      end
      // Computed before the register so reg_write is a clean flop output.
      w_dec.reg_write = ~w_dec.illegal & (w_dec.dest_reg != '0);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    if (rst) begin
      r_ctrl <= bubble();
    end else if (flush) begin
      r_ctrl <= bubble();
    end else if (!stall) begin
      r_ctrl <= w_dec;
    end
  end

  assign ex_valid    = r_ctrl.ex_valid;
  assign const_amt   = r_ctrl.const_amt;
  assign amt_sel     = r_ctrl.amt_sel;
  assign shift_func  = r_ctrl.shift_func;
  assign logic_func  = r_ctrl.logic_func;
  assign add_sub     = r_ctrl.add_sub;
  assign final_func  = r_ctrl.final_func;
  assign alu_src_imm = r_ctrl.alu_src_imm;
  assign imm32       = r_ctrl.imm32;
  assign ovf_chk     = r_ctrl.ovf_chk;
  assign reg_write   = r_ctrl.reg_write;
  assign dest_reg    = r_ctrl.dest_reg;
  assign illegal     = r_ctrl.illegal;

endmodule
